// File: rtl/ror_iter.sv
// rtl/ror_iter.sv - multi-cycle rotate unit (ROR_ITER_DIR_EN adds a left-rotate dir input)
module ror_iter #(
  parameter int WIDTH = 32,  // only 32 is supported
  parameter int STEP  = 1    // 1, 2, 4 or 8 bits per ROTATE cycle
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] RotateBits,
`ifdef ROR_ITER_DIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] Rz,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE   = 1'b0,
    ROTATE = 1'b1
  } state_t;

  // Step size sized to the 5-bit remaining-count so comparisons stay width-matched.
  localparam logic [4:0] STEP_V = 5'(STEP);

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [4:0]         cnt;
  logic [4:0]         k;
  logic               last_step;
  logic [2*WIDTH-1:0] dbl_r;
  logic [WIDTH-1:0]   rot_next;
`ifdef ROR_ITER_DIR_EN
  logic               dir_q;
  logic [2*WIDTH-1:0] dbl_l;
`endif

  // Only the low five amount bits select a rotation; the rest are don't-care.
  logic unused_amount_bits;
  assign unused_amount_bits = ^RotateBits[WIDTH-1:5];

  // Per-cycle shift amount k = min(STEP, cnt); the edge that consumes the remainder is final.
  always_comb begin
    k         = (cnt < STEP_V) ? cnt : STEP_V;
    last_step = (cnt <= STEP_V);
  end

  // Rotation by k done on a doubled word, so k = 0 naturally returns acc unchanged.
  always_comb begin
    dbl_r    = {acc, acc} >> k;
`ifdef ROR_ITER_DIR_EN
    dbl_l    = {acc, acc} << k;
    rot_next = dir_q ? dbl_l[2*WIDTH-1:WIDTH] : dbl_r[WIDTH-1:0];
`else
    rot_next = dbl_r[WIDTH-1:0];
`endif
  end

  // Control FSM with registered outputs; Rz is only written on the final ROTATE edge.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      Rz    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef ROR_ITER_DIR_EN
      dir_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= Ra;
            cnt   <= RotateBits[4:0];
            busy  <= 1'b1;
            state <= ROTATE;
`ifdef ROR_ITER_DIR_EN
            dir_q <= dir;
`endif
          end
        end
        ROTATE: begin
          acc <= rot_next;
          cnt <= cnt - k;
          if (last_step) begin
            Rz    <= rot_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ror_iter.sv
// tb/tb_ror_iter.sv - self-checking bench for ror_iter (STEP=1 and STEP=4 instances)
module tb_ror_iter;

  logic        clock = 1'b0;
  logic        clear;
  logic        go;
  logic        dir;
  logic [31:0] ra;
  logic [31:0] rb;
  int          sel;
  int          vectors = 0;
  int          miscompares = 0;

  logic [31:0] rz0, rz1;
  logic        busy0, busy1, done0, done1;
  logic        start0, start1;

  always #5 clock = ~clock;

  assign start0 = go && (sel == 0);
  assign start1 = go && (sel == 1);

  wire [31:0] rz_s   = (sel == 1) ? rz1   : rz0;
  wire        busy_s = (sel == 1) ? busy1 : busy0;
  wire        done_s = (sel == 1) ? done1 : done0;

  ror_iter #(.WIDTH(32), .STEP(1)) u_step1 (
    .clock      (clock),
    .clear      (clear),
    .start      (start0),
    .Ra         (ra),
    .RotateBits (rb),
`ifdef ROR_ITER_DIR_EN
    .dir        (dir),
`endif
    .Rz         (rz0),
    .busy       (busy0),
    .done       (done0)
  );

  ror_iter #(.WIDTH(32), .STEP(4)) u_step4 (
    .clock      (clock),
    .clear      (clear),
    .start      (start1),
    .Ra         (ra),
    .RotateBits (rb),
`ifdef ROR_ITER_DIR_EN
    .dir        (dir),
`endif
    .Rz         (rz1),
    .busy       (busy1),
    .done       (done1)
  );

  // Reference: bit i of a right rotate by n is bit (i+n) mod 32; left uses (i-n) mod 32.
  function automatic logic [31:0] model_rot(input logic [31:0] a, input int n, input bit left);
    logic [31:0] r;
    for (int i = 0; i < 32; i++)
      r[i] = left ? a[(i - n + 32) % 32] : a[(i + n) % 32];
    return r;
  endfunction

  function automatic int step_of(input int u);
    return (u == 1) ? 4 : 1;
  endfunction

  // Number of ROTATE edges: max(1, ceil(n/STEP)).
  function automatic int model_edges(input int n, input int step);
    return (n == 0) ? 1 : (n + step - 1) / step;
  endfunction

  // One complete operation on unit u; m counts negedges after the start edge until done is seen.
  task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b, input bit d,
                        input logic [31:0] exp, input string name);
    int m, bc, want;
    want = model_edges(int'(b[4:0]), step_of(u));
    @(negedge clock);
    sel = u; ra = a; rb = b; dir = d; go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    m  = 0;
    bc = busy_s ? 1 : 0;
    while (!done_s && m < 64) begin
      @(negedge clock);
      m++;
      vectors++;
      if (busy_s && done_s) begin
        miscompares++;
        $display("FAIL %s busy_and_done: both high at cycle %0d", name, m);
      end
      if (busy_s) bc++;
    end
    vectors++;
    if (done_s !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done_timeout: done=%b required 1", name, done_s);
    end
    vectors++;
    if (m !== want) begin
      miscompares++;
      $display("FAIL %s latency: got %0d required %0d", name, m, want);
    end
    vectors++;
    if (rz_s !== exp) begin
      miscompares++;
      $display("FAIL %s Rz: got %08h required %08h", name, rz_s, exp);
    end
    vectors++;
    if (bc !== want) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, bc, want);
    end
    @(negedge clock);
    vectors++;
    if (done_s !== 1'b0 || busy_s !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_pulse: done=%b busy=%b required 0 0", name, done_s, busy_s);
    end
  endtask

  task automatic test_reset();
    clear = 1'b0; go = 1'b0; sel = 0; ra = '0; rb = '0; dir = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (rz0 !== 32'h0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_step1: Rz=%08h busy=%b done=%b required 0 0 0", rz0, busy0, done0);
    end
    vectors++;
    if (rz1 !== 32'h0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_step4: Rz=%08h busy=%b done=%b required 0 0 0", rz1, busy1, done1);
    end
    clear = 1'b1;
  endtask

  task automatic test_directed();
    run_op(0, 32'h0000_0001, 32'd1,  1'b0, 32'h8000_0000, "ror1_step1");
    run_op(0, 32'h1234_5678, 32'd4,  1'b0, 32'h8123_4567, "ror4_step1");
    run_op(1, 32'h1234_5678, 32'd4,  1'b0, 32'h8123_4567, "ror4_step4");
    run_op(0, 32'hDEAD_BEEF, 32'h20, 1'b0, 32'hDEAD_BEEF, "ror32_step1");
    run_op(1, 32'hDEAD_BEEF, 32'h20, 1'b0, 32'hDEAD_BEEF, "ror32_step4");
    run_op(0, 32'hDEAD_BEEF, 32'h21, 1'b0, 32'hEF56_DF77, "ror33_step1");
    run_op(0, 32'h8000_0001, 32'd31, 1'b0, 32'h0000_0003, "ror31_step1");
    run_op(1, 32'h8000_0001, 32'd31, 1'b0, 32'h0000_0003, "ror31_step4");
  endtask

  task automatic test_busy_ignore();
    int m;
    @(negedge clock);
    sel = 0; ra = 32'h0000_FFFF; rb = 32'd16; dir = 1'b0; go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    m  = 0;
    while (!done_s && m < 64) begin
      @(negedge clock);
      m++;
      if (m == 2) begin
        go = 1'b1; ra = 32'h0; rb = 32'd5;
      end else if (m == 3) begin
        go = 1'b0;
      end
    end
    vectors++;
    if (m !== 16) begin
      miscompares++;
      $display("FAIL busy_ignore latency: got %0d required 16", m);
    end
    vectors++;
    if (rz_s !== 32'hFFFF_0000) begin
      miscompares++;
      $display("FAIL busy_ignore Rz: got %08h required ffff0000", rz_s);
    end
    @(negedge clock);
    vectors++;
    if (busy_s !== 1'b0 || done_s !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ignore relaunch: busy=%b done=%b required 0 0", busy_s, done_s);
    end
  endtask

  task automatic test_reset_midop();
    int m, seen;
    logic [31:0] a;
    @(negedge clock);
    sel = 0; ra = $urandom; rb = 32'd20; dir = 1'b0; go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    for (m = 0; m < 4; m++) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    vectors++;
    if (rz0 !== 32'h0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midop: Rz=%08h busy=%b done=%b required 0 0 0", rz0, busy0, done0);
    end
    clear = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done0) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_midop stray_done: got %0d pulses required 0", seen);
    end
    a = $urandom;
    run_op(0, a, 32'd20, 1'b0, model_rot(a, 20, 1'b0), "after_reset");
  endtask

  task automatic test_back_to_back();
    int m, want;
    logic [31:0] a1, a2;
    a1 = $urandom;
    a2 = $urandom;
    @(negedge clock);
    sel = 1; ra = a1; rb = 32'd9; dir = 1'b0; go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    m  = 0;
    while (!done_s && m < 64) begin
      @(negedge clock);
      m++;
    end
    vectors++;
    if (m !== 3 || rz_s !== model_rot(a1, 9, 1'b0)) begin
      miscompares++;
      $display("FAIL b2b first: latency %0d Rz %08h required 3 %08h", m, rz_s, model_rot(a1, 9, 1'b0));
    end
    ra = a2; rb = 32'd13; go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    vectors++;
    if (done_s !== 1'b0 || busy_s !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b accept: done=%b busy=%b required 0 1", done_s, busy_s);
    end
    want = model_edges(13, 4);
    m = 0;
    while (!done_s && m < 64) begin
      @(negedge clock);
      m++;
    end
    vectors++;
    if (m !== want || rz_s !== model_rot(a2, 13, 1'b0)) begin
      miscompares++;
      $display("FAIL b2b second: latency %0d Rz %08h required %0d %08h", m, rz_s, want, model_rot(a2, 13, 1'b0));
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    bit d;
    int u;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      u = i % 2;
`ifdef ROR_ITER_DIR_EN
      d = 1'($urandom_range(0, 1));
`else
      d = 1'b0;
`endif
      run_op(u, a, b, d, model_rot(a, int'(b[4:0]), d), "random");
    end
  endtask

`ifdef ROR_ITER_DIR_EN
  task automatic test_dir();
    run_op(0, 32'h8000_0001, 32'd1, 1'b1, 32'h0000_0003, "rol1_step1");
    run_op(0, 32'h8000_0001, 32'd1, 1'b0, 32'hC000_0000, "ror1_dir0");
    run_op(1, 32'h8000_0001, 32'd6, 1'b1, 32'h0000_0060, "rol6_step4");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_midop();
    test_back_to_back();
`ifdef ROR_ITER_DIR_EN
    test_dir();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
    $fatal(1);
  end

endmodule
